// File: rtl/mips_pkg.sv
// Shared MIPS decode-stage types and constants: register index type,
// register-file size, default stall latencies and a register decode helper.
package mips_pkg;

    localparam int NUM_REGS       = 32;
    localparam int DEF_ALU_STALL  = 0;
    localparam int DEF_LOAD_STALL = 1;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    // One-hot select of a register; r0 decodes to nothing because it is hardwired.
    function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_idx_t idx);
        logic [NUM_REGS-1:0] vec;
        vec = {NUM_REGS{1'b0}};
        if (idx != REG_ZERO) begin
            vec[idx] = 1'b1;
        end else begin
            vec = {NUM_REGS{1'b0}};
        end
        return vec;
    endfunction

endpackage

// File: rtl/id_hazard_ctrl_if.sv
// Decode/execute/writeback handshake bundle of the hazard controller.
// master drives the pipeline side, slave is the controller.
interface id_hazard_ctrl_if
    import mips_pkg::*;
#(
    parameter int STALL_CNT_W = 16
);
    logic                   id_valid;
    reg_idx_t               id_rs;
    reg_idx_t               id_rt;
    logic                   id_use_rs;
    logic                   id_use_rt;
    reg_idx_t               id_rd;
    logic                   id_we;
    logic                   id_is_load;
    logic                   ex_ready;
    logic                   wb_valid;
    reg_idx_t               wb_rd;
    logic                   stall;
    logic                   issue;
    logic                   fwd_rs;
    logic                   fwd_rt;
    logic [NUM_REGS-1:0]    pending_mask;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        output id_rd, id_we, id_is_load, ex_ready, wb_valid, wb_rd,
        input  stall, issue, fwd_rs, fwd_rt, pending_mask, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
        input  id_rd, id_we, id_is_load, ex_ready, wb_valid, wb_rd,
        output stall, issue, fwd_rs, fwd_rt, pending_mask, stall_cnt
    );

endinterface

// File: rtl/id_sb_entry.sv
// One scoreboard entry: pending flag plus a countdown of cycles until the
// producer's result reaches the bypass network.
module id_sb_entry #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set,
    input  logic [CNT_W-1:0] set_cnt,
    input  logic             clr,
    output logic             pending,
    output logic [CNT_W-1:0] cnt
);

    logic             pending_nxt_s;
    logic [CNT_W-1:0] cnt_nxt_s;

    // Next state: decrement, then writeback clear, then a new issue overrides both.
    always_comb begin
        pending_nxt_s = pending;
        cnt_nxt_s     = cnt;
        if (cnt != {CNT_W{1'b0}}) begin
            cnt_nxt_s = cnt - CNT_W'(1);
        end else begin
            cnt_nxt_s = cnt;
        end
        if (clr) begin
            pending_nxt_s = 1'b0;
            cnt_nxt_s     = {CNT_W{1'b0}};
        end else begin
            pending_nxt_s = pending;
        end
        if (set) begin
            pending_nxt_s = 1'b1;
            cnt_nxt_s     = set_cnt;
        end else begin
            pending_nxt_s = pending_nxt_s;
        end
    end

    // Entry state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
            cnt     <= {CNT_W{1'b0}};
        end else begin
            pending <= pending_nxt_s;
            cnt     <= cnt_nxt_s;
        end
    end

endmodule

// File: rtl/id_hazard_ctrl.sv
// Decode-stage register scoreboard and issue controller: decides issue/stall,
// selects bypass per source and counts hazard-stall cycles.
module id_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int ALU_STALL   = DEF_ALU_STALL,
    parameter int LOAD_STALL  = DEF_LOAD_STALL,
    parameter int CNT_W       = 2,
    parameter int STALL_CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    id_hazard_ctrl_if.slave sb
);

    localparam logic [CNT_W-1:0] ALU_CNT  = CNT_W'(ALU_STALL);
    localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(LOAD_STALL);

    logic [NUM_REGS-1:0]    pending_s;
    logic [CNT_W-1:0]       cnt_s [NUM_REGS];
    logic [NUM_REGS-1:0]    set_vec_s;
    logic [NUM_REGS-1:0]    clr_vec_s;
    logic [CNT_W-1:0]       set_cnt_s;
    logic                   hz_rs_s;
    logic                   hz_rt_s;
    logic                   fwd_rs_s;
    logic                   fwd_rt_s;
    logic                   stall_s;
    logic                   issue_s;
    logic [STALL_CNT_W-1:0] stall_cnt_r;

    // Per-source hazard/bypass from the pre-edge entry, so an instruction sees its own old rd.
    always_comb begin
        hz_rs_s  = 1'b0;
        hz_rt_s  = 1'b0;
        fwd_rs_s = 1'b0;
        fwd_rt_s = 1'b0;
        if (sb.id_use_rs && (sb.id_rs != REG_ZERO) && pending_s[sb.id_rs]) begin
            hz_rs_s  = (cnt_s[sb.id_rs] != {CNT_W{1'b0}});
            fwd_rs_s = (cnt_s[sb.id_rs] == {CNT_W{1'b0}});
        end else begin
            hz_rs_s  = 1'b0;
            fwd_rs_s = 1'b0;
        end
        if (sb.id_use_rt && (sb.id_rt != REG_ZERO) && pending_s[sb.id_rt]) begin
            hz_rt_s  = (cnt_s[sb.id_rt] != {CNT_W{1'b0}});
            fwd_rt_s = (cnt_s[sb.id_rt] == {CNT_W{1'b0}});
        end else begin
            hz_rt_s  = 1'b0;
            fwd_rt_s = 1'b0;
        end
    end

    assign stall_s = sb.id_valid & (hz_rs_s | hz_rt_s);
    assign issue_s = sb.id_valid & ~stall_s & sb.ex_ready;

    // Entry set/clear strobes; reg_onehot never selects r0, which keeps entry 0 idle.
    always_comb begin
        set_vec_s = {NUM_REGS{1'b0}};
        clr_vec_s = {NUM_REGS{1'b0}};
        set_cnt_s = ALU_CNT;
        if (issue_s && sb.id_we) begin
            set_vec_s = reg_onehot(sb.id_rd);
        end else begin
            set_vec_s = {NUM_REGS{1'b0}};
        end
        if (sb.wb_valid) begin
            clr_vec_s = reg_onehot(sb.wb_rd);
        end else begin
            clr_vec_s = {NUM_REGS{1'b0}};
        end
        if (sb.id_is_load) begin
            set_cnt_s = LOAD_CNT;
        end else begin
            set_cnt_s = ALU_CNT;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        id_sb_entry #(
            .CNT_W   (CNT_W)
        ) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .set     (set_vec_s[i]),
            .set_cnt (set_cnt_s),
            .clr     (clr_vec_s[i]),
            .pending (pending_s[i]),
            .cnt     (cnt_s[i])
        );
    end

    // Saturating hazard-stall counter for performance monitoring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= {STALL_CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_r <= stall_cnt_r + STALL_CNT_W'(1);
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign sb.stall        = stall_s;
    assign sb.issue        = issue_s;
    assign sb.fwd_rs       = fwd_rs_s;
    assign sb.fwd_rt       = fwd_rt_s;
    assign sb.pending_mask = pending_s;
    assign sb.stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_id_hazard_ctrl.sv
// Directed bench for id_hazard_ctrl: a default-latency instance for the
// pipeline scenarios and a long-load instance for counter saturation.
module tb_id_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    id_hazard_ctrl_if #(.STALL_CNT_W(16)) bus ();
    id_hazard_ctrl_if #(.STALL_CNT_W(16)) sbus ();

    id_hazard_ctrl #(
        .ALU_STALL(0), .LOAD_STALL(1), .CNT_W(2), .STALL_CNT_W(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (bus.slave)
    );

    id_hazard_ctrl #(
        .ALU_STALL(0), .LOAD_STALL(15), .CNT_W(4), .STALL_CNT_W(16)
    ) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .sb    (sbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // valid rs rt use_rs use_rt rd we load ready wb_valid wb_rd
    task automatic drv(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic we, input logic ld, input logic rdy,
                       input logic wbv, input logic [4:0] wbrd);
        bus.id_valid   = v;
        bus.id_rs      = rs;
        bus.id_rt      = rt;
        bus.id_use_rs  = urs;
        bus.id_use_rt  = urt;
        bus.id_rd      = rd;
        bus.id_we      = we;
        bus.id_is_load = ld;
        bus.ex_ready   = rdy;
        bus.wb_valid   = wbv;
        bus.wb_rd      = wbrd;
    endtask

    task automatic sat_drv(input logic v, input logic [4:0] rs, input logic [4:0] rd,
                           input logic we, input logic ld, input logic rdy);
        sbus.id_valid   = v;
        sbus.id_rs      = rs;
        sbus.id_rt      = 5'd0;
        sbus.id_use_rs  = v;
        sbus.id_use_rt  = 1'b0;
        sbus.id_rd      = rd;
        sbus.id_we      = we;
        sbus.id_is_load = ld;
        sbus.ex_ready   = rdy;
        sbus.wb_valid   = 1'b0;
        sbus.wb_rd      = 5'd0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;

        // Reset held with random stimulus on both instances
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b1, 5'($urandom),
                1'b1, 1'($urandom), 1'b1, 1'($urandom), 5'($urandom));
            sat_drv(1'b1, 5'($urandom), 5'($urandom), 1'b1, 1'b1, 1'b1);
            @(negedge clk);
        end
        chk("rst_mask", bus.pending_mask, 32'h0);
        chk("rst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        chk("rst_stall", 32'(bus.stall), 32'h0);

        drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        sat_drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Sources not pending
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        #1;
        chk("idle_issue", 32'(bus.issue), 32'h1);
        chk("idle_fwd_rs", 32'(bus.fwd_rs), 32'h0);
        chk("idle_fwd_rt", 32'(bus.fwd_rt), 32'h0);

        // add r5 then sub using r5 via EX->EX bypass
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        #1;
        chk("add_issue", 32'(bus.issue), 32'h1);
        @(posedge clk); #1;
        chk("add_mask", bus.pending_mask, 32'h0000_0020);
        @(negedge clk);
        drv(1'b1, 5'd5, 5'd3, 1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        #1;
        chk("sub_stall", 32'(bus.stall), 32'h0);
        chk("sub_issue", 32'(bus.issue), 32'h1);
        chk("sub_fwd_rs", 32'(bus.fwd_rs), 32'h1);
        chk("sub_fwd_rt", 32'(bus.fwd_rt), 32'h0);
        @(posedge clk); #1;
        chk("sub_mask", bus.pending_mask, 32'h0000_0060);

        // lw r7 then load-use on rt
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
        #1;
        chk("lw7_issue", 32'(bus.issue), 32'h1);
        @(posedge clk); #1;
        chk("lw7_mask", bus.pending_mask, 32'h0000_00E0);
        @(negedge clk);
        drv(1'b1, 5'd0, 5'd7, 1'b0, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0);
        #1;
        chk("lu_stall", 32'(bus.stall), 32'h1);
        chk("lu_issue", 32'(bus.issue), 32'h0);
        chk("lu_fwd_rt", 32'(bus.fwd_rt), 32'h0);
        @(posedge clk); #1;
        chk("lu_stall_cnt", 32'(bus.stall_cnt), 32'h1);
        chk("lu_stall_2nd", 32'(bus.stall), 32'h0);
        chk("lu_issue_2nd", 32'(bus.issue), 32'h1);
        chk("lu_fwd_rt_2nd", 32'(bus.fwd_rt), 32'h1);
        @(posedge clk); #1;
        chk("lu_mask", bus.pending_mask, 32'h0000_01E0);
        chk("lu_stall_cnt_hold", 32'(bus.stall_cnt), 32'h1);

        // Writeback/issue race on r9: issue wins
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
        @(posedge clk); #1;
        chk("lw9_mask", bus.pending_mask, 32'h0000_03E0);
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 5'd9);
        #1;
        chk("race_issue", 32'(bus.issue), 32'h1);
        @(posedge clk); #1;
        chk("race_mask", bus.pending_mask, 32'h0000_03E0);
        @(negedge clk);
        drv(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0);
        #1;
        chk("race_stall", 32'(bus.stall), 32'h1);
        @(posedge clk); #1;
        chk("race_stall_cnt", 32'(bus.stall_cnt), 32'h2);
        chk("race_stall_2nd", 32'(bus.stall), 32'h0);
        chk("race_fwd_rs", 32'(bus.fwd_rs), 32'h1);
        @(negedge clk);
        drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9);
        @(posedge clk); #1;
        chk("wb9_mask", bus.pending_mask, 32'h0000_01E0);

        // Register 0 never pending
        @(negedge clk);
        drv(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0);
        @(posedge clk); #1;
        chk("r0_lw_mask", bus.pending_mask, 32'h0000_01E0);
        @(negedge clk);
        drv(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0);
        #1;
        chk("r0_stall", 32'(bus.stall), 32'h0);
        chk("r0_fwd_rs", 32'(bus.fwd_rs), 32'h0);
        chk("r0_issue", 32'(bus.issue), 32'h1);
        @(posedge clk); #1;
        chk("r0_wb_mask", bus.pending_mask, 32'h0000_01E0);

        // Back-pressure without hazard
        @(negedge clk);
        drv(1'b1, 5'd5, 5'd0, 1'b1, 1'b0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        #1;
        chk("bp_issue", 32'(bus.issue), 32'h0);
        chk("bp_stall", 32'(bus.stall), 32'h0);
        chk("bp_fwd_rs", 32'(bus.fwd_rs), 32'h1);
        @(posedge clk); #1;
        chk("bp_mask", bus.pending_mask, 32'h0000_01E0);
        chk("bp_stall_cnt", 32'(bus.stall_cnt), 32'h2);
        @(negedge clk);
        drv(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);

        // Saturation: self-dependent lw r11 stalls 15 of every 16 cycles
        sat_drv(1'b1, 5'd11, 5'd11, 1'b1, 1'b1, 1'b1);
        repeat (70000) @(posedge clk);
        @(negedge clk);
        chk("sat_cnt", 32'(sbus.stall_cnt), 32'h0000_FFFF);
        for (int k = 0; k < 20 && sbus.stall !== 1'b1; k++) @(negedge clk);
        chk("sat_mid_stall", 32'(sbus.stall), 32'h1);
        chk("sat_mask", sbus.pending_mask, 32'h0000_0800);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_stall", 32'(sbus.stall), 32'h0);
        chk("arst_mask", sbus.pending_mask, 32'h0);
        chk("arst_stall_cnt", 32'(sbus.stall_cnt), 32'h0);
        chk("arst_main_mask", bus.pending_mask, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
